// File: rtl/log_approx_pkg.sv
// Shared constants, FSM state type and polynomial coefficient table for logarithm_approximate.
// All values are signed Q16.16.
package log_approx_pkg;

   localparam int FRAC_BITS = 16;
   localparam logic signed [31:0] LN2       = 32'sh0000B172;
   localparam logic signed [31:0] LN_OF_MIN = 32'shFFF4E8DF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NORM  = 3'd1,
      S_POLY  = 3'd2,
      S_SCALE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Coefficient k[idx] of log2(1+f) ~= sum k[i]*f^i on f in [0,1); zero beyond the degree.
   function automatic logic signed [31:0] coef(input int deg, input int idx);
      logic signed [31:0] r;
      r = '0;
      case (deg)
         2: case (idx)
               1:       r = 32'sd88254;
               2:       r = -32'sd22718;
               default: r = '0;
            endcase
         4: case (idx)
               1:       r = 32'sd94538;
               2:       r = -32'sd46753;
               3:       r = 32'sd27925;
               4:       r = -32'sd10174;
               default: r = '0;
            endcase
         default: case (idx)
               1:       r = 32'sd93514;
               2:       r = -32'sd38290;
               3:       r = 32'sd10313;
               default: r = '0;
            endcase
      endcase
      return r;
   endfunction

endpackage

// File: rtl/log_normalize.sv
// Combinational leading-one detector: splits a positive Q16.16 operand into exponent e
// and mantissa fraction f = a/2^e - 1.0 (Q16.16, truncated).
module log_normalize
   import log_approx_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0]        i_a,
   output logic signed [BITS-1:0] o_e,
   output logic [BITS-1:0]        o_f
);
   localparam int PW = $clog2(BITS);

   logic [PW-1:0]   w_p;
   logic [PW-1:0]   w_shamt;
   logic [BITS-1:0] w_shift;

   always_comb begin
      w_p = '0;
      for (int i = 0; i < BITS; i++) begin
         if (i_a[i]) w_p = PW'(i);
      end
   end

   // Leading one moves to bit BITS-2; the FRAC_BITS bits below it are the fraction.
   assign w_shamt = PW'(BITS - 2) - w_p;
   assign w_shift = i_a << w_shamt;
   assign o_f     = (w_shift >> (BITS - 2 - FRAC_BITS)) & BITS'((1 << FRAC_BITS) - 1);
   assign o_e     = $signed(BITS'(w_p)) - BITS'(FRAC_BITS);

endmodule

// File: rtl/logarithm_approximate.sv
// Multi-cycle natural logarithm of a signed Q16.16 operand: normalise, Horner polynomial
// for log2(1+f), scale by ln2. Optional domain_err port: LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN.
module logarithm_approximate
   import log_approx_pkg::*;
#(
   parameter int BITS        = 32,
   parameter     PRECISION   = "FIXED_16_16",
   parameter int POLY_DEGREE = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] a,
   output logic            out_valid,
   output logic [BITS-1:0] c
`ifdef LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN
   ,
   output logic            domain_err
`endif
);
   localparam int CW = 3;

   if (PRECISION != "FIXED_16_16") begin : g_bad_precision
      $error("logarithm_approximate: only FIXED_16_16 is supported");
   end
   if (POLY_DEGREE < 2 || POLY_DEGREE > 4) begin : g_bad_degree
      $error("logarithm_approximate: POLY_DEGREE must be 2..4");
   end

   logic signed [BITS-1:0] w_k [0:4];
   for (genvar gi = 0; gi <= 4; gi++) begin : g_coef
      assign w_k[gi] = BITS'(coef(POLY_DEGREE, gi));
   end

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [BITS-1:0]        r_a;
   logic signed [BITS-1:0] r_e;
   logic signed [BITS-1:0] r_f;
   logic signed [BITS-1:0] r_acc;
   logic                   r_neg;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [BITS-1:0]        r_c;
`ifdef LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN
   logic                   r_domain_err;
`endif

   logic signed [BITS-1:0]   w_norm_e;
   logic [BITS-1:0]          w_norm_f;
   logic signed [BITS-1:0]   w_scale_in;
   logic signed [2*BITS-1:0] w_mul_a;
   logic signed [2*BITS-1:0] w_mul_b;
   logic signed [2*BITS-1:0] w_prod_full;
   logic signed [BITS-1:0]   w_prod;

   log_normalize #(.BITS(BITS)) u_norm (
      .i_a (r_a),
      .o_e (w_norm_e),
      .o_f (w_norm_f)
   );

   // Single shared multiplier: Horner step in POLY, ln2 scaling in SCALE.
   assign w_scale_in = (r_e <<< FRAC_BITS) + r_acc;

   always_comb begin
      w_mul_a = (2*BITS)'(r_acc);
      w_mul_b = (2*BITS)'(r_f);
      if (r_state == S_SCALE) begin
         w_mul_a = (2*BITS)'(w_scale_in);
         w_mul_b = (2*BITS)'(LN2);
      end
   end

   assign w_prod_full = w_mul_a * w_mul_b;
   assign w_prod      = BITS'(w_prod_full >>> FRAC_BITS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_e         <= '0;
         r_f         <= '0;
         r_acc       <= '0;
         r_neg       <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_c         <= '0;
`ifdef LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN
         r_domain_err <= 1'b0;
`endif
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_in_ready && in_valid) begin
                  r_a        <= a;
                  r_neg      <= a[BITS-1] || (a == '0);
                  r_in_ready <= 1'b0;
                  r_state    <= S_NORM;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            S_NORM: begin
               r_e     <= w_norm_e;
               r_f     <= $signed(w_norm_f);
               r_acc   <= w_k[POLY_DEGREE];
               r_cnt   <= CW'(POLY_DEGREE - 1);
               r_state <= S_POLY;
            end
            S_POLY: begin
               r_acc <= w_prod + w_k[r_cnt];
               if (r_cnt == '0) r_state <= S_SCALE;
               else             r_cnt   <= r_cnt - CW'(1);
            end
            S_SCALE: begin
               // Non-positive operands still take the full latency, then clamp.
               r_c         <= r_neg ? BITS'(LN_OF_MIN) : w_prod;
               r_out_valid <= 1'b1;
`ifdef LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN
               r_domain_err <= r_neg;
`endif
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign c         = r_c;
`ifdef LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN
   assign domain_err = r_domain_err;
`endif

endmodule

// File: doc/logarithm_approximate.md
LOGARITHM_APPROXIMATE -- requirements
Module: logarithm_approximate

Interface
REQ-001 SHALL have parameter BITS, default 32: data width.
REQ-002 SHALL have parameter PRECISION, default "FIXED_16_16": number format, signed Q16.16 (the only supported value).
REQ-003 SHALL have parameter POLY_DEGREE, default 3: log2 polynomial degree, range 2..4.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: operand a is valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-008 SHALL have port a, input, BITS: operand, signed Q16.16.
REQ-009 SHALL have port out_valid, output, 1: one-cycle result strobe.
REQ-010 SHALL have port c, output, BITS: ln(a), signed Q16.16.
REQ-011 SHALL have port domain_err, output, 1, present only under the macro in REQ-029: the result came from a<=0.

Function
REQ-012 SHALL accept an operand only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL ignore and drop in_valid while busy; no queuing.
REQ-014 SHALL use FSM states IDLE -> NORM (1 cycle) -> POLY (POLY_DEGREE cycles, counter) -> SCALE (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-015 SHALL assert out_valid for exactly the DONE cycle, POLY_DEGREE+3 cycles after the accept edge (6 at default); in_ready SHALL return to 1 on the next cycle.
REQ-016 SHALL hold c stable from DONE until the next DONE.
REQ-017 NORM SHALL locate the leading one of a at position p (0..30), set e = p-16 (signed integer), and set f = (a normalised to [1,2)) - 1.0, Q16.16 in [0,1).
REQ-018 POLY SHALL compute Horner acc = acc*f + k[i], one step per cycle, i = POLY_DEGREE-1 down to 0, starting from acc = k[POLY_DEGREE].
REQ-019 SCALE SHALL compute c = (e<<16 + acc) * LN2.
REQ-020 SHALL use one shared signed BITSxBITS multiplier; each product SHALL be the 2*BITS-bit result arithmetically shifted right by 16 (truncation toward minus infinity), low BITS kept.
REQ-021 SHALL, for a<=0 (sign bit set or zero), run the same fixed-latency sequence and output c = LN_OF_MIN = 0xFFF4E8DF.
REQ-022 SHALL produce |c - ln(a)| <= 0.01 (655 LSB) for all a>0 at POLY_DEGREE=3.
REQ-023 SHALL give a = 0x00010000 exactly e=0, f=0.

Reset
REQ-024 SHALL, while rst is 1, hold: state IDLE, in_ready 0, out_valid 0, c 0, domain_err 0, counter and acc 0.
REQ-025 SHALL have in_ready 1 on the first clock edge after rst deasserts.
REQ-026 SHALL abort an operation in flight when rst asserts, with no out_valid for it afterwards.

Configuration
REQ-027 SHALL have macro LOGARITHM_APPROXIMATE_DOMAIN_ERR_EN.
REQ-028 With the macro undefined: domain_err port absent; a<=0 behaves per REQ-021.
REQ-029 With the macro defined: domain_err port present; domain_err is 1 alongside out_valid when the operand was <=0, else 0, and is held like c.

Structure
REQ-030 SHALL place in package log_approx_pkg: FSM state enum, FRAC_BITS=16, LN2=0x0000B172, LN_OF_MIN=0xFFF4E8DF, coefficient table k.
REQ-031 SHALL define the degree-3 coefficients as k0=0, k1=93514, k2=-38290, k3=10313 (Q16.16).
REQ-032 SHALL factor leading-one detection and normalisation into the sub-module log_normalize (combinational, outputs e and f).

Verification
REQ-033 SHALL cover: a=0x00010000 -> out_valid at cycle 6 after accept, c within +-655 of 0, in_ready 0 during cycles 1-5.
REQ-034 SHALL cover: a=0x0002B7E1 (e) -> c within 0x10000 +- 655.
REQ-035 SHALL cover: a=0x00000001 -> c within 0xFFF4E8DF +- 655; a=0x7FFFFFFF -> c within 0x000A65AF +- 655 (ln 32768 = 10.397).
REQ-036 SHALL cover: a=0 and a=0x80000000 -> c=0xFFF4E8DF, domain_err=1 when the macro is defined, same latency.
REQ-037 SHALL cover: in_valid held high with a new operand every cycle -> only operands presented while in_ready=1 are processed, one result per 7 cycles.
REQ-038 SHALL cover: rst pulse at cycle 3 of an operation -> no out_valid, c=0, in_ready=1 after release, next operand correct.
